pfpu_sincos_arb: RTL and testbench

Arbiter and sequencer that lets two requesters share one `pfpu_sincos` pipeline inside the PFPU. Each requester has a valid/ready issue port. The block grants one operation per cycle, alternating between requesters when both ask. It drives the sincos operands from registers and tags every in-flight operation, so each result that comes back is steered to the requester that issued it. It also reports in-flight status (`idle`) and a sticky error if a result arrives that was not expected.

---
 rtl/pfpu_sincos_arb.sv | 130 +++++++++++++
 tb/tb_pfpu_sincos_arb.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pfpu_sincos_arb.sv
// Two-requester arbiter and issue sequencer in front of a shared pfpu_sincos pipeline.
// Round-robin grants, a tag pipeline steers each result back to its issuer.
module pfpu_sincos_arb #(
  parameter int LATENCY = 3
) (
  input  logic        sys_clk,
  input  logic        alu_rst,
  input  logic        hold,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic        req0_cos,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic        req1_cos,
  output logic        req1_ready,
  output logic [31:0] sc_a,
  output logic        sc_cos,
  output logic        sc_valid,
  input  logic [31:0] sc_r,
  input  logic        sc_valid_o,
  output logic [31:0] res_r,
  output logic        res0_valid,
  output logic        res1_valid,
  output logic        idle,
  output logic        err
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(LATENCY + 2);

  logic               last_q, last_d;
  logic               sc_valid_q, sc_valid_d;
  logic [DATA_W-1:0]  sc_a_q, sc_a_d;
  logic               sc_cos_q, sc_cos_d;
  logic               issue_id_q, issue_id_d;
  logic [LATENCY-1:0] tag_v_q, tag_v_d;
  logic [LATENCY-1:0] tag_id_q, tag_id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic xfer0, xfer1, xfer, tag_v, tag_id, retire;

  // Grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!alu_rst && !hold) begin
      if (req0_valid && (!req1_valid || last_q)) req0_ready = 1'b1;
      else if (req1_valid)                       req1_ready = 1'b1;
    end
  end

  assign xfer0  = req0_valid & req0_ready;
  assign xfer1  = req1_valid & req1_ready;
  assign xfer   = xfer0 | xfer1;
  assign tag_v  = tag_v_q[LATENCY-1];
  assign tag_id = tag_id_q[LATENCY-1];
  assign retire = sc_valid_o & tag_v;

  always_comb begin
    last_d     = last_q;
    sc_valid_d = xfer;
    sc_a_d     = sc_a_q;
    sc_cos_d   = sc_cos_q;
    issue_id_d = issue_id_q;
    if (xfer1) begin
      last_d     = 1'b1;
      sc_a_d     = req1_a;
      sc_cos_d   = req1_cos;
      issue_id_d = 1'b1;
    end else if (xfer0) begin
      last_d     = 1'b0;
      sc_a_d     = req0_a;
      sc_cos_d   = req0_cos;
      issue_id_d = 1'b0;
    end

    // Tag entry 0 follows the issue register so the tail lines up with sc_valid_o.
    tag_v_d     = tag_v_q;
    tag_id_d    = tag_id_q;
    tag_v_d[0]  = sc_valid_q;
    tag_id_d[0] = issue_id_q;
    for (int i = 1; i < LATENCY; i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end

    cnt_d = cnt_q;
    if (xfer && !retire)      cnt_d = cnt_q + CNT_W'(1);
    else if (!xfer && retire) cnt_d = cnt_q - CNT_W'(1);

    err_d = err_q | (sc_valid_o ^ tag_v);
  end

  // Control state: reset applies here only.
  always_ff @(posedge sys_clk) begin
    if (alu_rst) begin
      last_q     <= 1'b1;
      sc_valid_q <= 1'b0;
      tag_v_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      last_q     <= last_d;
      sc_valid_q <= sc_valid_d;
      tag_v_q    <= tag_v_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Operand and tag-id storage: no reset needed, qualified by the valids above.
  always_ff @(posedge sys_clk) begin
    sc_a_q     <= sc_a_d;
    sc_cos_q   <= sc_cos_d;
    issue_id_q <= issue_id_d;
    tag_id_q   <= tag_id_d;
  end

  assign sc_a       = sc_a_q;
  assign sc_cos     = sc_cos_q;
  assign sc_valid   = sc_valid_q;
  assign res_r      = sc_r;
  assign res0_valid = sc_valid_o & tag_v & ~tag_id;
  assign res1_valid = sc_valid_o & tag_v & tag_id;
  assign idle       = (cnt_q == '0);
  assign err        = err_q;

endmodule

// File: tb/tb_pfpu_sincos_arb.sv
// Table-driven bench for pfpu_sincos_arb with a behavioural sincos pipeline model.
// Each table row is one clock cycle of requester stimulus plus the expected grant.
module tb_pfpu_sincos_arb;

  localparam int LAT = 3;
  localparam int N   = 41;

  logic        sys_clk = 1'b0;
  logic        alu_rst = 1'b1;
  logic        hold = 1'b0;
  logic        req0_valid = 1'b0, req0_cos = 1'b0, req1_valid = 1'b0, req1_cos = 1'b0;
  logic [31:0] req0_a = '0, req1_a = '0;
  logic        req0_ready, req1_ready;
  logic [31:0] sc_a, sc_r, res_r;
  logic        sc_cos, sc_valid, sc_valid_o;
  logic        res0_valid, res1_valid, idle, err;
  logic        force_vo = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int step   = 0;

  always #5 sys_clk = ~sys_clk;

  pfpu_sincos_arb #(.LATENCY(LAT)) dut (
    .sys_clk(sys_clk), .alu_rst(alu_rst), .hold(hold),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_cos(req0_cos), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_cos(req1_cos), .req1_ready(req1_ready),
    .sc_a(sc_a), .sc_cos(sc_cos), .sc_valid(sc_valid),
    .sc_r(sc_r), .sc_valid_o(sc_valid_o),
    .res_r(res_r), .res0_valid(res0_valid), .res1_valid(res1_valid),
    .idle(idle), .err(err)
  );

  // Reference values for the operands used here; other operands map to an arbitrary tag.
  function automatic logic [31:0] sc_fn(input logic [31:0] a, input logic c);
    if (a == 32'h0)               return c ? 32'h3f800000 : 32'h00000000;
    if (a == 32'h1000 && c)       return 32'hbf800000;
    return a + 32'h40000000 + {31'b0, c};
  endfunction

  // Sincos unit model: LAT register stages, shares alu_rst.
  logic [LAT-1:0] pv;
  logic [31:0]    pr [LAT];
  always @(posedge sys_clk) begin
    if (alu_rst) pv <= '0;
    else         pv <= {pv[LAT-2:0], sc_valid};
    pr[0] <= sc_fn(sc_a, sc_cos);
    for (int i = 1; i < LAT; i++) pr[i] <= pr[i-1];
  end
  assign sc_valid_o = pv[LAT-1] | force_vo;
  assign sc_r       = pr[LAT-1];

  typedef struct {
    logic        rst, hold, v0, c0, v1, c1;
    logic [31:0] a0, a1;
    int          g;   // expected grant: -1 none, 0 or 1
  } vec_t;

  vec_t vec [N];
  bit   live [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic setv(input int k, input logic r, input logic h,
                      input logic v0, input logic [31:0] a0, input logic c0,
                      input logic v1, input logic [31:0] a1, input logic c1, input int g);
    vec[k].rst = r;  vec[k].hold = h;
    vec[k].v0 = v0;  vec[k].a0 = a0; vec[k].c0 = c0;
    vec[k].v1 = v1;  vec[k].a1 = a1; vec[k].c1 = c1;
    vec[k].g = g;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      setv(k, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, -1);
      live[k] = 1'b0;
    end
    // Reset with both requesting: no grants.
    setv(0, 1, 0, 1, 32'h0, 1, 1, 32'h1000, 1, -1);
    setv(1, 1, 0, 1, 32'h0, 1, 1, 32'h1000, 1, -1);
    // Single cos(0) from requester 0.
    setv(3, 0, 0, 1, 32'h0, 1, 0, 32'h0, 0, 0);
    // Fresh reset, then both valid: 0,1,0,1.
    setv(8, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0, -1);
    for (int k = 9; k < 13; k++)
      setv(k, 0, 0, 1, 32'h0, 1, 1, 32'h1000, 1, (k % 2 == 1) ? 0 : 1);
    // Requester 1 alone three times, then ties go 0 then 1.
    for (int k = 17; k < 20; k++) setv(k, 0, 0, 0, 32'h0, 0, 1, 32'h800 + k, 0, 1);
    setv(20, 0, 0, 1, 32'h0, 0, 1, 32'h1000, 1, 0);
    setv(21, 0, 0, 1, 32'h0, 0, 1, 32'h1000, 1, 1);
    // Hold blocks both; release grants in the same cycle.
    setv(23, 0, 1, 1, 32'h0, 1, 1, 32'h1000, 1, -1);
    setv(24, 0, 1, 1, 32'h0, 1, 1, 32'h1000, 1, -1);
    setv(25, 0, 0, 1, 32'h0, 1, 1, 32'h1000, 1, 0);
    // Three back-to-back ops, then reset discards them.
    for (int k = 30; k < 33; k++) setv(k, 0, 0, 1, 32'h0, 0, 0, 32'h0, 0, 0);
    setv(33, 1, 0, 1, 32'h0, 0, 1, 32'h1000, 1, -1);
    setv(34, 1, 0, 1, 32'h0, 0, 1, 32'h1000, 1, -1);

    for (int k = 0; k < N; k++) begin
      @(negedge sys_clk);
      step       = k;
      alu_rst    = vec[k].rst;
      hold       = vec[k].hold;
      req0_valid = vec[k].v0;  req0_a = vec[k].a0;  req0_cos = vec[k].c0;
      req1_valid = vec[k].v1;  req1_a = vec[k].a1;  req1_cos = vec[k].c1;
      #1;
      chk("req0_ready", {31'b0, req0_ready}, {31'b0, vec[k].g == 0});
      chk("req1_ready", {31'b0, req1_ready}, {31'b0, vec[k].g == 1});
      begin
        bit exp_sv;
        exp_sv = (k > 0) && (vec[k-1].g >= 0);
        chk("sc_valid", {31'b0, sc_valid}, {31'b0, exp_sv});
        if (exp_sv) begin
          chk("sc_a", sc_a, (vec[k-1].g == 1) ? vec[k-1].a1 : vec[k-1].a0);
          chk("sc_cos", {31'b0, sc_cos}, {31'b0, (vec[k-1].g == 1) ? vec[k-1].c1 : vec[k-1].c0});
        end
      end
      begin
        int  m;
        bit  e0, e1, busy;
        m  = k - (LAT + 1);
        e0 = (m >= 0) && live[m] && (vec[m].g == 0);
        e1 = (m >= 0) && live[m] && (vec[m].g == 1);
        chk("res0_valid", {31'b0, res0_valid}, {31'b0, e0});
        chk("res1_valid", {31'b0, res1_valid}, {31'b0, e1});
        if (e0) chk("res_r0", res_r, sc_fn(vec[m].a0, vec[m].c0));
        if (e1) chk("res_r1", res_r, sc_fn(vec[m].a1, vec[m].c1));
        busy = 1'b0;
        for (int j = k - (LAT + 1); j < k; j++)
          if (j >= 0 && live[j]) busy = 1'b1;
        chk("idle", {31'b0, idle}, {31'b0, !busy});
      end
      chk("err", {31'b0, err}, 32'h0);
      live[k] = (vec[k].g >= 0);
      if (vec[k].rst)
        for (int j = k - LAT; j < k; j++)
          if (j >= 0) live[j] = 1'b0;
    end

    // Spurious result with an empty tag pipeline.
    @(negedge sys_clk);
    step = N; alu_rst = 1'b0; hold = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; force_vo = 1'b1;
    #1;
    chk("err_pre", {31'b0, err}, 32'h0);
    chk("spur_res0", {31'b0, res0_valid}, 32'h0);
    chk("spur_res1", {31'b0, res1_valid}, 32'h0);
    @(negedge sys_clk);
    step = N + 1; force_vo = 1'b0;
    #1;
    chk("err_set", {31'b0, err}, 32'h1);
    chk("err_idle", {31'b0, idle}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      step = N + 2 + k;
      #1;
      chk("err_sticky", {31'b0, err}, 32'h1);
    end
    @(negedge sys_clk);
    step = N + 5; alu_rst = 1'b1;
    #1;
    chk("err_in_rst", {31'b0, err}, 32'h1);
    @(negedge sys_clk);
    step = N + 6; alu_rst = 1'b0;
    #1;
    chk("err_clear", {31'b0, err}, 32'h0);
    chk("idle_end", {31'b0, idle}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
